key_onehot_capture: RTL and testbench
=====================================

Name: key_onehot_capture

Overview:
Upstream front-end for encoder_8to3. It synchronises and debounces 8 raw key/switch lines, turns each debounced press into a queued event, and presents events one at a time as a clean one-hot 8-bit word. Output uses a valid/ready handshake. onehot_out feeds the encoder's "in" port directly, so the encoder never sees multi-hot or bouncing inputs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the debounced state before that state flips (legal range 1..255).
CNT_W, 8, width of each per-bit debounce counter (must hold DEBOUNCE_CYCLES-1).

Ports:
clk  input  1  single system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
key_in  input  8  raw asynchronous key lines, active high
out_ready  input  1  consumer can accept the current one-hot word
onehot_out  output  8  one-hot key code while out_valid=1; 8'b0 otherwise
out_valid  output  1  onehot_out holds an event
drop_pulse  output  1  one-cycle pulse when a press is lost because that key is already pending

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, rst_n asserted low clears state immediately with no clock edge. All state clears: sync flops, debounced state, counters, pending, onehot_out=0, out_valid=0, drop_pulse=0. A release mid-operation discards all queued and presented events.
- Synchroniser: 2-flop per bit (s1, s2).
- Debounce, per bit:
  - If s2 == db, the counter clears.
  - Otherwise the counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and s2 != db, db takes s2 and the counter clears.
  - A single glitch cycle restarts the count.
- Press event: db bit goes 0->1 on this edge. Releases generate no event.
- pending[7:0]:
  - next = (pending & ~load_mask) | press_events.
  - If a press_event hits a bit with pending=1 that is not being loaded this cycle, drop_pulse=1 next cycle and pending is unchanged.
  - A press on the same bit that is loaded this cycle sets pending (it counts as a new press).
  - A press on the bit currently held in onehot_out sets pending normally.
- Output FSM:
  - IDLE (out_valid=0, onehot_out=0): if pending!=0, load the lowest-index set bit as one-hot into onehot_out, clear that bit from pending (load_mask), set out_valid, go to PRESENT.
  - PRESENT: hold onehot_out and out_valid stable while out_ready=0.
  - On out_valid & out_ready: if pending (register value this cycle) !=0, load the next lowest bit in the same edge, giving back-to-back events with no bubble. Otherwise clear onehot_out and out_valid and go to IDLE.
  - out_ready is ignored in IDLE.
- Priority: bit 0 highest. onehot_out is never multi-hot.
- Latency:
  - Edge 1 is the first edge sampling key_in=1.
  - db and pending set at edge DEBOUNCE_CYCLES+2.
  - out_valid rises after edge DEBOUNCE_CYCLES+3 (edge 7 at default), with the consumer ready and the queue empty.
- Throughput: one event per cycle with out_ready held high.

Test Plan:
1. Reset, then key_in=8'h04 held, DEBOUNCE_CYCLES=4, out_ready=1 -> out_valid=1, onehot_out=8'b0000_0100 after edge 7 for exactly 1 cycle; the encoder sees out=3'b010. drop_pulse stays 0.
2. key_in bit 5 pulses high 3 cycles, low 1, high 3 (bounce) -> no event; then held 10 cycles -> a single event, onehot_out=8'b0010_0000.
3. out_ready=0; keys 1, 6, 3 pressed in separate bursts -> onehot_out=8'b0000_0010 held. Then raise out_ready -> 8'b0000_0010, 8'b0000_1000, 8'b0100_0000 on consecutive cycles, then out_valid=0, onehot_out=0.
4. out_ready=0; key 7 pressed, released, pressed again while its first event is pending (not yet loaded) -> drop_pulse=1 for one cycle. Exactly one 8'b1000_0000 is delivered.
5. key_in=8'hAE (multi-press, simultaneous), out_ready=1 -> events in order 8'h02, 8'h04, 8'h08, 8'h20, 8'h80, each one cycle, no drop_pulse.
6. Hold out_ready=0 with out_valid=1 and two events pending; pull rst_n low mid-cycle -> outputs 0 immediately. After release, no events appear until new presses.

Source files
------------

// File: rtl/key_onehot_capture.sv
// Key front-end for encoder_8to3: synchronises, debounces and queues 8 key presses,
// then presents them one at a time as a one-hot word over a valid/ready handshake.
module key_onehot_capture #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_in,
    input  logic       out_ready,
    output logic [7:0] onehot_out,
    output logic       out_valid,
    output logic       drop_pulse
);

    localparam logic IDLE    = 1'b0;
    localparam logic PRESENT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]            s1, s2;
    logic [7:0]            db, db_next;
    logic [7:0][CNT_W-1:0] cnt, cnt_next;
    logic [7:0]            press;
    logic [7:0]            pending;
    logic [7:0]            lowest;
    logic [7:0]            load_mask;
    logic                  load;
    logic                  state;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            db_next[i]  = db[i];
            cnt_next[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_next[i] = s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = db_next & ~db;

    // Two's-complement trick isolates the lowest set bit: bit 0 has top priority.
    assign lowest    = pending & (~pending + 8'd1);
    assign load      = (pending != 8'd0) && ((state == IDLE) || out_ready);
    assign load_mask = load ? lowest : 8'd0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= '0;
            s2  <= '0;
            db  <= '0;
            cnt <= '0;
        end else begin
            s1  <= key_in;
            s2  <= s1;
            db  <= db_next;
            cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            drop_pulse <= 1'b0;
        end else begin
            pending    <= (pending & ~load_mask) | press;
            drop_pulse <= |(press & pending & ~load_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            onehot_out <= '0;
        end else if (load) begin
            state      <= PRESENT;
            onehot_out <= lowest;
        end else if ((state == PRESENT) && out_ready) begin
            state      <= IDLE;
            onehot_out <= '0;
        end
    end

    assign out_valid = (state == PRESENT);

endmodule

// File: tb/tb_key_onehot_capture.sv
// Self-checking bench for key_onehot_capture: directed scenarios plus random key traffic,
// compared cycle by cycle against a history-window reference model.
module tb_key_onehot_capture;

    localparam int DC = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_in;
    logic       out_ready;
    logic [7:0] onehot_out;
    logic       out_valid;
    logic       drop_pulse;

    int n_checks = 0;
    int n_fails  = 0;
    int n_drops  = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    // Reference model state: key sample history, debounced view, pending set, presented word.
    logic [7:0] m_hist[$];
    logic [7:0] m_db;
    logic [7:0] m_pend;
    logic [7:0] m_out;
    logic       m_valid;
    logic       m_drop;

    key_onehot_capture #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .out_ready (out_ready),
        .onehot_out(onehot_out),
        .out_valid (out_valid),
        .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < DC + 1; i++) m_hist.push_back(8'h00);
        m_db    = '0;
        m_pend  = '0;
        m_out   = '0;
        m_valid = 1'b0;
        m_drop  = 1'b0;
    endtask

    // A key's debounced level flips once the last DC synchronised samples all disagree with it.
    task automatic model_update();
        logic [7:0] new_db;
        logic [7:0] prs;
        logic [7:0] loadbit;
        int         n;
        int         pick;
        bit         all_diff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n      = m_hist.size();
        new_db = m_db;
        for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= DC; j++)
                if (m_hist[n-1-j][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) new_db[b] = ~m_db[b];
        end
        prs     = new_db & ~m_db;
        loadbit = '0;
        if (m_pend != 8'h00 && (!m_valid || out_ready)) begin
            pick = 0;
            for (int i = 7; i >= 0; i--) if (m_pend[i]) pick = i;
            loadbit = 8'h01 << pick;
        end
        if (loadbit != 8'h00) begin
            m_out   = loadbit;
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_out   = '0;
            m_valid = 1'b0;
        end
        m_drop = |(prs & m_pend & ~loadbit);
        m_pend = (m_pend & ~loadbit) | prs;
        m_db   = new_db;
        m_hist.push_back(key_in);
        void'(m_hist.pop_front());
    endtask

    task automatic tick();
        if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(onehot_out);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("onehot_out", onehot_out, m_out);
        check("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
        check("drop_pulse", {7'd0, drop_pulse}, {7'd0, m_drop});
        if (drop_pulse === 1'b1) n_drops++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, 8'(got.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
    endtask

    task automatic clear_log();
        got.delete();
        n_drops = 0;
    endtask

    initial begin
        int idx;
        int hold;
        rst_n     = 1'b0;
        key_in    = '0;
        out_ready = 1'b0;
        model_reset();
        run(2);
        check("reset_onehot", onehot_out, 8'h00);
        check("reset_valid", {7'd0, out_valid}, 8'h00);
        rst_n = 1'b1;
        run(2);

        // 1: single key, latency and one-cycle presentation with consumer ready
        clear_log();
        key_in    = 8'h04;
        out_ready = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            check("t1_valid_at_edge", {7'd0, out_valid}, (e == 7) ? 8'h01 : 8'h00);
            if (e == 7) begin
                check("t1_onehot", onehot_out, 8'h04);
                idx = 0;
                for (int i = 0; i < 8; i++) if (onehot_out[i]) idx = i;
                check("t1_encoded", 8'(idx), 8'd2);
            end
        end
        key_in = '0;
        run(10);
        check("t1_drops", 8'(n_drops), 8'd0);

        // 2: bouncing key 5 yields nothing, then a steady hold yields one event
        clear_log();
        key_in = 8'h20; run(3);
        key_in = 8'h00; run(1);
        key_in = 8'h20; run(3);
        key_in = 8'h00; run(8);
        check("t2_bounce_events", 8'(got.size()), 8'd0);
        key_in = 8'h20; run(10);
        key_in = 8'h00; run(8);
        exp_q = '{8'h20};
        check_events("t2_event");

        // 3: three queued keys released back-to-back once the consumer is ready
        clear_log();
        out_ready = 1'b0;
        key_in = 8'h02; run(8); key_in = 8'h00; run(8);
        key_in = 8'h40; run(8); key_in = 8'h00; run(8);
        key_in = 8'h08; run(8); key_in = 8'h00; run(8);
        check("t3_held_onehot", onehot_out, 8'h02);
        check("t3_held_valid", {7'd0, out_valid}, 8'h01);
        out_ready = 1'b1;
        run(6);
        exp_q = '{8'h02, 8'h08, 8'h40};
        check_events("t3_order");
        check("t3_idle_onehot", onehot_out, 8'h00);
        check("t3_idle_valid", {7'd0, out_valid}, 8'h00);

        // 4: second press of a still-pending key is dropped
        clear_log();
        out_ready = 1'b0;
        key_in = 8'h01; run(8); key_in = 8'h00; run(8);
        key_in = 8'h80; run(8); key_in = 8'h00; run(8);
        key_in = 8'h80; run(8); key_in = 8'h00; run(8);
        check("t4_drops", 8'(n_drops), 8'd1);
        out_ready = 1'b1;
        run(6);
        exp_q = '{8'h01, 8'h80};
        check_events("t4_events");

        // 5: simultaneous multi-press drains in priority order
        clear_log();
        key_in = 8'hAE; run(14);
        key_in = 8'h00; run(8);
        exp_q = '{8'h02, 8'h04, 8'h08, 8'h20, 8'h80};
        check_events("t5_order");
        check("t5_drops", 8'(n_drops), 8'd0);

        // 6: asynchronous reset mid-cycle discards presented and queued events
        clear_log();
        out_ready = 1'b0;
        key_in = 8'h07; run(8);
        check("t6_pre_onehot", onehot_out, 8'h01);
        check("t6_pre_valid", {7'd0, out_valid}, 8'h01);
        #2;
        rst_n  = 1'b0;
        key_in = 8'h00;
        model_reset();
        #1;
        check("t6_async_onehot", onehot_out, 8'h00);
        check("t6_async_valid", {7'd0, out_valid}, 8'h00);
        check("t6_async_drop", {7'd0, drop_pulse}, 8'h00);
        run(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        clear_log();
        run(20);
        check("t6_no_events", 8'(got.size()), 8'd0);

        // Random key bursts of varying length with a randomly stalling consumer
        for (int b = 0; b < 60; b++) begin
            key_in = 8'($urandom);
            hold   = $urandom_range(1, 12);
            for (int c = 0; c < hold; c++) begin
                out_ready = ($urandom_range(0, 9) < 7);
                tick();
            end
        end
        key_in    = '0;
        out_ready = 1'b1;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
